// File: rtl/mo_mul_sched.sv
// Round-robin front end for one shared fixed-latency modular multiplier.
// Each issued operation is tagged with its requester so the result can be routed back MUL_LAT cycles later.
package ntt_pkg;
   parameter int DATA_WIDTH = 12;
endpackage

module mo_mul_sched
   import ntt_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int MUL_LAT = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_a,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_b,
   output logic [N_REQ-1:0]              req_ready,
   output logic [DATA_WIDTH-1:0]         mul_a,
   output logic [DATA_WIDTH-1:0]         mul_b,
   output logic                          mul_issue,
   input  logic [DATA_WIDTH-1:0]         mul_result,
   output logic [N_REQ-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          busy
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]              grant;
   logic [PW-1:0]              idx;
   logic                       found;
   logic                       transfer;
   logic [MUL_LAT-1:0]         vld_q, vld_d;
   logic [MUL_LAT-1:0][PW-1:0] id_q, id_d;

   // Search downward so the candidate closest to rr_ptr is the last one written.
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = PW'((int'(rr_ptr_q) + k) % N_REQ);
         if (req_valid[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   assign transfer  = found && !flush;
   assign mul_issue = transfer;
   assign req_ready = transfer ? (N_REQ'(1) << grant) : '0;
   assign mul_a     = transfer ? req_a[int'(grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign mul_b     = transfer ? req_b[int'(grant)*DATA_WIDTH +: DATA_WIDTH] : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      vld_d    = '0;
      id_d     = id_q;
      if (flush) begin
         rr_ptr_d = '0;
      end else begin
         if (transfer) begin
            rr_ptr_d = (grant == PW'(N_REQ - 1)) ? '0 : grant + PW'(1);
         end
         vld_d[0] = transfer;
         for (int i = MUL_LAT - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
         end
      end
      id_d[0] = grant;
      for (int i = MUL_LAT - 1; i > 0; i--) begin
         id_d[i] = id_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         vld_q    <= '0;
         id_q     <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         vld_q    <= vld_d;
         id_q     <= id_d;
      end
   end

   // Oldest tag stage lines up with the multiplier output.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = vld_q[MUL_LAT-1] && (id_q[MUL_LAT-1] == PW'(gi));
   end

   assign rsp_data = mul_result;
   assign busy     = |vld_q;

endmodule

// File: doc/mo_mul_sched.md
# mo_mul_sched

Round-robin scheduler that shares one pipelined modular multiplier (KRED, KLMM or any fixed-latency `mo_mul` variant) among `N_REQ` requesters. Each cycle it accepts at most one operand pair and drives it into the multiplier. It tags the issued operation with the requester index and steers the result back to that requester exactly `MUL_LAT` cycles later. It sits between the NTT butterfly / point-wise multiply units and the single shared multiplier instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `MUL_LAT`, default 4: issue-to-result latency of the attached multiplier in cycles, ≥1. For example, KRED latency is `KRED_MULCUT+KRED_L+1`.
- `DATA_WIDTH`, from `ntt_pkg`: operand and result width.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `flush`, in, 1: synchronous abort of all in-flight operations.
- `req_valid`, in, `N_REQ`: requester i has an operand pair.
- `req_a`, in, `N_REQ*DATA_WIDTH`: operand a. Requester i is at bits `[i*DATA_WIDTH +: DATA_WIDTH]`. Range 0..Q.
- `req_b`, in, `N_REQ*DATA_WIDTH`: operand b, same packing.
- `req_ready`, out, `N_REQ`: one-hot grant. Combinational.
- `mul_a`, out, `DATA_WIDTH`: to multiplier `a`.
- `mul_b`, out, `DATA_WIDTH`: to multiplier `b`.
- `mul_issue`, out, 1: an operation is issued this cycle.
- `mul_result`, in, `DATA_WIDTH`: from multiplier `result`.
- `rsp_valid`, out, `N_REQ`: one-hot; result for requester i is on `rsp_data`.
- `rsp_data`, out, `DATA_WIDTH`: equals `mul_result` (pass-through).
- `busy`, out, 1: at least one operation is in flight.

## Operation
**Arbitration**
- Round-robin pointer `rr_ptr` (`$clog2(N_REQ)` bits).
- The grant goes to the first i with `req_valid[i]`, searching `rr_ptr, rr_ptr+1, …` with wrap modulo `N_REQ`.
- `req_ready[g]=1` for the granted g only. All zero when no `req_valid` is set or when `flush=1`.
- A transfer occurs when `req_valid[g] && req_ready[g]`. The requester holds its operands until it sees ready. Ready may depend on valid.
- On a transfer: `rr_ptr <= (g+1) mod N_REQ`. Otherwise `rr_ptr` holds.
- With all requesters continuously valid, the grant sequence is strictly 0,1,…,N_REQ-1,0,…

**Issue**
- `mul_a`/`mul_b` are a combinational mux of the granted operands. They are 0 when nothing is granted.
- `mul_issue` = transfer.

**Tag pipeline**
- `MUL_LAT` stages of {valid, id}.
- Stage 0 loads {transfer, g}. Each stage shifts every cycle with no stall.
- The last stage is decoded one-hot onto `rsp_valid`.
- `rsp_data` = `mul_result` unconditionally. It is meaningful only when `rsp_valid` is non-zero.
- There is no output backpressure: requesters must accept a response in the cycle it is presented.

**Flush**
- On a clock edge with `flush=1`, all tag-stage valids clear and `rr_ptr` resets to 0.
- No transfer occurs in a flush cycle. Results already in the multiplier are discarded (no `rsp_valid`).
- A response that would appear in the flush cycle itself is still presented, because the last stage is registered.

**Busy**
- `busy` = OR of all tag-stage valids.

## Timing
- **Reset values:** `rst_n=0` asynchronously clears `rr_ptr`=0 and all tag valids. This gives `rsp_valid`=0 and `busy`=0. `req_ready`, `mul_issue`, `mul_a`, `mul_b` follow combinationally; they are 0 while `req_valid`=0.
- **Throughput:** one issue per cycle; back-to-back issues from different or the same requester are allowed.
- **Latency:** a transfer in cycle t gives `rsp_valid[g]=1` in cycle t+`MUL_LAT`, for exactly one cycle per operation. Order is preserved.
- **Simultaneous issue and response:** fully independent. A response and a new issue for the same requester may coincide.
- **Reset mid-operation:** all in-flight results are lost. No `rsp_valid` after reset release until new issues have aged `MUL_LAT` cycles.
- **`MUL_LAT=1`:** single tag stage; the response appears the cycle after issue.

## Test plan
- **Single op:** reset, then `req_valid`=0001 with a=5, b=7 against a stub multiplier (delay line of `MUL_LAT`, a·b mod 3329) → `req_ready`=0001 in the same cycle; `rsp_valid`=0001 with `rsp_data`=35 exactly 4 cycles later; `busy` high for 4 cycles.
- **Full contention:** `req_valid`=1111 held for 8 cycles → grants 0,1,2,3,0,1,2,3. Responses are in the same order, each offset by `MUL_LAT`, with data correct per requester.
- **Wrap and skip:** after a grant to 2, `req_valid`=1001 → grant 3, then 0.
- **Flush:** issue 3 ops on consecutive cycles, assert `flush` on the cycle after the third → `req_ready`=0 that cycle; no `rsp_valid` for any of the flushed ops; `busy`=0 next cycle; next grant starts from requester 0.
- **Async reset mid-stream:** pulse `rst_n` low between clock edges while 4 ops are in flight → `rsp_valid`/`busy` drop immediately; no stale responses after release.
- **Random soak:** random `req_valid`, operands 0..3328, `MUL_LAT`∈{1,4,7} → scoreboard matches every response to its requester and operands; no requester waits more than `N_REQ-1` grants while valid.
